// File: rtl/resize_uart_framer_pkg.sv
// Shared constants and types for the thumbnail UART framer: sync bytes,
// FSM encoding and the running payload checksum helper.
package resize_uart_framer_pkg;

  localparam logic [7:0] SYNC0_BYTE = 8'hA5;
  localparam logic [7:0] SYNC1_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC0   = 3'd1,
    ST_SYNC1   = 3'd2,
    ST_SEQ     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CSUM    = 3'd5
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 UART byte serializer. ready is high when idle and during the final
// stop-bit cycle, so a byte loaded then follows the previous one back-to-back.
module uart_tx_ser #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [3:0]    LAST_DATA = 4'd8;
  localparam logic [3:0]    STOP_BIT  = 4'd9;

  logic          active_r;
  logic [BW-1:0] baud_r;
  logic [3:0]    bit_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          ready_r;
  logic          done_r;
  logic          bit_end_s;
  logic          pre_end_s;

  assign bit_end_s = (baud_r == BAUD_LAST);
  assign pre_end_s = (bit_r == STOP_BIT) && (baud_r == BAUD_PRE);

  // Bit sequencing: bit_r 0 = start, 1..8 = data LSB first, 9 = stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= 1'b0;
      baud_r   <= {BW{1'b0}};
      bit_r    <= 4'd0;
      shift_r  <= 8'h00;
      tx_r     <= 1'b1;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
    end else if (start && ready_r) begin
      active_r <= 1'b1;
      baud_r   <= {BW{1'b0}};
      bit_r    <= 4'd0;
      shift_r  <= data;
      tx_r     <= 1'b0;
      ready_r  <= 1'b0;
      done_r   <= 1'b0;
    end else if (active_r) begin
      done_r  <= pre_end_s;
      ready_r <= pre_end_s || (bit_end_s && (bit_r == STOP_BIT));
      if (bit_end_s) begin
        baud_r <= {BW{1'b0}};
        bit_r  <= bit_r + 4'd1;
        if (bit_r == STOP_BIT) begin
          active_r <= 1'b0;
          tx_r     <= 1'b1;
        end else if (bit_r == LAST_DATA) begin
          tx_r <= 1'b1;
        end else begin
          tx_r    <= shift_r[0];
          shift_r <= {1'b0, shift_r[7:1]};
        end
      end else begin
        baud_r <= baud_r + BAUD_ONE;
      end
    end else begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end
  end

  assign tx    = tx_r;
  assign ready = ready_r;
  assign done  = done_r;

endmodule

// File: rtl/resize_uart_framer.sv
// Buffers resize-stage bytes in a small FIFO and sends each frame as
// SYNC0 SYNC1 SEQ payload CHECKSUM over an 8N1 UART line.
module resize_uart_framer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PAYLOAD_LEN  = 1024,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_serial,
  output logic       busy,
  output logic       frame_done,
  output logic       err_drop,
  output logic [7:0] frame_seq
);
  import resize_uart_framer_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_LEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  state_t        state_r;
  state_t        nxt_state_s;
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   wr_ptr_nxt_s;
  logic [AW:0]   rd_ptr_nxt_s;
  logic          full_s;
  logic          full_nxt_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic          frame_go_s;
  logic          sent_r;
  logic          ld_s;
  logic [7:0]    ld_data_s;
  logic          ser_ready_s;
  logic          ser_done_s;
  logic [7:0]    csum_r;
  logic [CW-1:0] pay_cnt_r;
  logic          in_ready_r;
  logic          busy_r;
  logic          frame_done_r;
  logic          err_drop_r;
  logic [7:0]    frame_seq_r;

  assign empty_s      = (wr_ptr_r == rd_ptr_r);
  assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_s       = in_valid && (state_r != ST_IDLE) && !full_s;
  assign drop_s       = in_valid && ((state_r == ST_IDLE) || full_s);
  assign frame_go_s   = (state_r == ST_IDLE) && frame_start;
  assign wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
  assign rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
  assign full_nxt_s   = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                        (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);

  // Next-state decode; every byte-sending state advances on the serializer done pulse.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      ST_IDLE:    nxt_state_s = frame_start ? ST_SYNC0 : ST_IDLE;
      ST_SYNC0:   nxt_state_s = ser_done_s ? ST_SYNC1 : ST_SYNC0;
      ST_SYNC1:   nxt_state_s = ser_done_s ? ST_SEQ : ST_SYNC1;
      ST_SEQ:     nxt_state_s = ser_done_s ? ST_PAYLOAD : ST_SEQ;
      ST_PAYLOAD: begin
        if (ser_done_s && (pay_cnt_r == LAST_CNT)) begin
          nxt_state_s = ST_CSUM;
        end else begin
          nxt_state_s = ST_PAYLOAD;
        end
      end
      ST_CSUM:    nxt_state_s = ser_done_s ? ST_IDLE : ST_CSUM;
      default:    nxt_state_s = ST_IDLE;
    endcase
  end

  // Byte issue: the next state's byte is loaded in the done cycle so bytes run back-to-back.
  always_comb begin
    ld_s      = 1'b0;
    ld_data_s = 8'h00;
    pop_s     = 1'b0;
    if ((state_r != ST_IDLE) && ser_ready_s && (ser_done_s || !sent_r)) begin
      case (nxt_state_s)
        ST_SYNC0: begin
          ld_s      = 1'b1;
          ld_data_s = SYNC0_BYTE;
        end
        ST_SYNC1: begin
          ld_s      = 1'b1;
          ld_data_s = SYNC1_BYTE;
        end
        ST_SEQ: begin
          ld_s      = 1'b1;
          ld_data_s = frame_seq_r;
        end
        ST_PAYLOAD: begin
          ld_s      = !empty_s;
          pop_s     = !empty_s;
          ld_data_s = fifo_mem_r[rd_ptr_r[AW-1:0]];
        end
        ST_CSUM: begin
          ld_s      = 1'b1;
          ld_data_s = csum_r;
        end
        default: begin
          ld_s      = 1'b0;
          ld_data_s = 8'h00;
          pop_s     = 1'b0;
        end
      endcase
    end else begin
      ld_s = 1'b0;
    end
  end

  // FIFO storage; emptiness is carried by the pointers alone.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= in_data;
    end
  end

  // Control state, FIFO pointers, checksum and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= {(AW+1){1'b0}};
      rd_ptr_r     <= {(AW+1){1'b0}};
      sent_r       <= 1'b0;
      csum_r       <= 8'h00;
      pay_cnt_r    <= {CW{1'b0}};
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_drop_r   <= 1'b0;
      frame_seq_r  <= 8'h00;
    end else begin
      state_r      <= nxt_state_s;
      busy_r       <= (nxt_state_s != ST_IDLE);
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      in_ready_r   <= !full_nxt_s;
      frame_done_r <= (state_r == ST_CSUM) && ser_done_s;
      if ((state_r == ST_CSUM) && ser_done_s) begin
        frame_seq_r <= frame_seq_r + 8'd1;
      end
      if (state_r == ST_IDLE) begin
        sent_r <= 1'b0;
      end else if (ser_done_s) begin
        sent_r <= ld_s;
      end else if (ld_s) begin
        sent_r <= 1'b1;
      end
      if (frame_go_s) begin
        csum_r    <= 8'h00;
        pay_cnt_r <= {CW{1'b0}};
      end else if (pop_s) begin
        csum_r    <= csum_add(csum_r, ld_data_s);
        pay_cnt_r <= pay_cnt_r + CNT_ONE;
      end
      // A drop in the same cycle as frame_start is still reported.
      if (drop_s) begin
        err_drop_r <= 1'b1;
      end else if (frame_go_s) begin
        err_drop_r <= 1'b0;
      end
    end
  end

  uart_tx_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .start(ld_s),
    .data (ld_data_s),
    .tx   (tx_serial),
    .ready(ser_ready_s),
    .done (ser_done_s)
  );

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign err_drop   = err_drop_r;
  assign frame_seq  = frame_seq_r;

endmodule

// File: tb/tb_resize_uart_framer.sv
// Scoreboard bench: stimulus queues expected line bytes, a UART monitor
// decodes tx_serial and compares each decoded byte against the queue.
module tb_resize_uart_framer;
  localparam int CPB   = 4;
  localparam int PLEN  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME_CYC = (PLEN + 4) * 10 * CPB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx_serial;
  logic       busy;
  logic       frame_done;
  logic       err_drop;
  logic [7:0] frame_seq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int tx_edges = 0;
  logic tx_prev = 1'b1;
  logic [7:0] exp_q[$];

  resize_uart_framer #(
    .CLKS_PER_BIT(CPB),
    .PAYLOAD_LEN (PLEN),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_serial  (tx_serial),
    .busy       (busy),
    .frame_done (frame_done),
    .err_drop   (err_drop),
    .frame_seq  (frame_seq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_serial !== tx_prev) tx_edges <= tx_edges + 1;
    tx_prev <= tx_serial;
    if (frame_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    start_cyc = cyc;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input int prev, input logic [7:0] seq_after);
    int k = 0;
    while (done_cnt == prev && k < 1000) begin
      tick(1);
      k++;
    end
    check("frame_done_seen", 32'(done_cnt != prev), 32'd1);
    check("frame_time", 32'(done_cyc - start_cyc), 32'(FRAME_CYC));
    tick(5);
    check("frame_done_once", 32'(done_cnt - prev), 32'd1);
    check("frame_seq", 32'(frame_seq), 32'(seq_after));
    check("busy_after", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // UART monitor: mid-bit sampling, bytes interrupted by reset are discarded.
  initial begin : uart_mon
    logic [7:0] b;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_serial === 1'b0) begin
        aborted = 1'b0;
        repeat (CPB / 2) begin @(negedge clk); aborted = aborted | rst; end
        if (!aborted) check("start_bit", 32'(tx_serial), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); aborted = aborted | rst; end
          b[i] = tx_serial;
        end
        repeat (CPB) begin @(negedge clk); aborted = aborted | rst; end
        if (!aborted) begin
          check("stop_bit", 32'(tx_serial), 32'd1);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h, expected no byte", b);
          end else begin
            check("uart_byte", 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int prev;
    int e0;
    int k;
    // 1: reset idle
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_tx", 32'(tx_serial), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seq", 32'(frame_seq), 32'd0);
    check("rst_err", 32'(err_drop), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    e0 = tx_edges;
    tick(100);
    check("idle_no_edges", 32'(tx_edges - e0), 32'd0);

    // 2: basic frame
    prev = done_cnt;
    push_exp(8'hA5); push_exp(8'h5A); push_exp(8'h00);
    push_exp(8'h01); push_exp(8'h02); push_exp(8'h03); push_exp(8'h04); push_exp(8'h0A);
    start_frame();
    check("busy_in_frame", 32'(busy), 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    finish_frame(prev, 8'h01);

    // 3: second frame, checksum wraps
    tick(10);
    prev = done_cnt;
    push_exp(8'hA5); push_exp(8'h5A); push_exp(8'h01);
    push_exp(8'hFF); push_exp(8'hFF); push_exp(8'hFF); push_exp(8'hFF); push_exp(8'hFC);
    start_frame();
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    finish_frame(prev, 8'h02);

    // 4: overflow during SYNC0
    tick(10);
    prev = done_cnt;
    push_exp(8'hA5); push_exp(8'h5A); push_exp(8'h02);
    push_exp(8'h10); push_exp(8'h11); push_exp(8'h12); push_exp(8'h13); push_exp(8'h46);
    start_frame();
    for (int i = 0; i < 6; i++) begin
      in_data  = 8'h10 + 8'(i);
      in_valid = 1'b1;
      tick(1);
      if (i == 2) check("in_ready_after_3", 32'(in_ready), 32'd1);
      if (i == 3) check("in_ready_after_4", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("err_drop_overflow", 32'(err_drop), 32'd1);
    finish_frame(prev, 8'h03);
    check("in_ready_recovered", 32'(in_ready), 32'd1);

    // 6a: frame_start while busy is ignored; frame_start clears err_drop
    tick(10);
    prev = done_cnt;
    push_exp(8'hA5); push_exp(8'h5A); push_exp(8'h03);
    push_exp(8'h21); push_exp(8'h22); push_exp(8'h23); push_exp(8'h24); push_exp(8'h8A);
    start_frame();
    check("err_drop_cleared", 32'(err_drop), 32'd0);
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
    tick(50);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(150);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    finish_frame(prev, 8'h04);
    check("err_drop_clean_frame", 32'(err_drop), 32'd0);

    // 6b: in_valid in IDLE is dropped and sticky
    tick(10);
    send_byte(8'hEE);
    check("err_drop_idle", 32'(err_drop), 32'd1);
    tick(10);
    check("err_drop_sticky", 32'(err_drop), 32'd1);

    // 5: reset while the 2nd payload byte is on the line
    push_exp(8'hA5); push_exp(8'h5A); push_exp(8'h04); push_exp(8'h31);
    start_frame();
    check("err_drop_cleared2", 32'(err_drop), 32'd0);
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
    k = 0;
    while (cyc < start_cyc + 180 && k < 400) begin
      tick(1);
      k++;
    end
    rst = 1'b1;
    tick(1);
    check("midrst_tx", 32'(tx_serial), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_seq", 32'(frame_seq), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick(45);
    check("midrst_sb_drained", 32'(exp_q.size()), 32'd0);
    e0 = tx_edges;
    tick(20);
    check("midrst_line_quiet", 32'(tx_edges - e0), 32'd0);

    // 5 follow-up: fresh frame, SEQ restarts at 00, stale FIFO bytes gone
    prev = done_cnt;
    push_exp(8'hA5); push_exp(8'h5A); push_exp(8'h00);
    push_exp(8'h41); push_exp(8'h42); push_exp(8'h43); push_exp(8'h44); push_exp(8'h0A);
    start_frame();
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
    finish_frame(prev, 8'h01);

    tick(50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
